apb_ram_bridge: RTL and testbench
=================================

# apb_ram_bridge

Parametrised APB slave that bridges a single APB completer port onto a generic synchronous single-port RAM. It adds configurable data, address and RAM widths, byte-lane write strobes, and a RAM read latency of 1–8 cycles. A RAM-side stall input and error responses (PSLVERR) for out-of-range or misaligned addresses complete the feature set. It sits between the SoC APB interconnect and any on-chip SRAM macro or register-file RAM.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB/RAM data width; must be 8, 16, 32 or 64.
- RAM_ADDR_WIDTH, 10, RAM word-address width; DEPTH = 2**RAM_ADDR_WIDTH words.
- RAM_LATENCY, 1, cycles from RAM read acceptance to valid ram_rdata; legal range 1–8.
- BASE_ADDR, 0, byte address of RAM word 0; must be DATA_WIDTH/8 aligned.

Ports:
- CLK  in  1  single clock.
- nRST  in  1  asynchronous, active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid with PREADY.
- ram_ren  out  1  RAM read request.
- ram_wen  out  1  RAM write request.
- ram_addr  out  RAM_ADDR_WIDTH  RAM word address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_byte_en  out  DATA_WIDTH/8  RAM byte enables.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- ram_busy  in  1  RAM stall; request not accepted while high.

## Operation
- Define OFF = log2(DATA_WIDTH/8) and idx = (PADDR − BASE_ADDR) >> OFF.
- Error condition: PADDR < BASE_ADDR, idx ≥ DEPTH, or PADDR[OFF-1:0] ≠ 0.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** When PSEL & PENABLE, latch PWRITE, idx, PWDATA, PSTRB and the error flag.
  - Error → RESP.
  - Write with PSTRB == 0 → RESP with no RAM access and no error.
  - Otherwise → ISSUE.
- **ISSUE.** Drive ram_ren or ram_wen from the latched direction, with ram_addr, ram_wdata and ram_byte_en from the latched values.
  - Read byte_en is all ones.
  - The request is accepted on the first cycle with ram_busy = 0. Strobe and payload stay stable until acceptance.
  - Write accepted → RESP.
  - Read accepted → load cnt = RAM_LATENCY − 1, → WAIT.
- **WAIT.** If cnt == 0, capture ram_rdata into rdata_q and → RESP. Otherwise decrement cnt.
- **RESP.** PREADY = 1 for exactly one cycle.
  - PSLVERR = latched error.
  - PRDATA = rdata_q for a successful read, otherwise 0.
  - Then → IDLE.
- Once latched, a transfer always runs to completion. PSEL/PENABLE deasserting mid-transfer is a master protocol violation; the bridge ignores it and does not abort.
- Back-to-back transfers: a new access phase can be latched on the cycle after RESP.
- An error transfer never asserts ram_ren or ram_wen.
- Arithmetic: the subtraction is done at ADDR_WIDTH+1 bits so that the below-base borrow is detected, never wrapped.

## Timing
- Reset (nRST low, asynchronous): state = IDLE; PREADY, PSLVERR, ram_ren, ram_wen = 0; PRDATA, ram_addr, ram_wdata, ram_byte_en, rdata_q, cnt = 0. Reset asserted mid-transfer drops any pending RAM strobe immediately.
- PREADY is low in every state except RESP, so every transfer has at least one wait state.
- Access-phase cycles to PREADY high, counting the first PENABLE cycle as cycle 1:
  - Error or zero-strobe write: 2.
  - Write: 3 + stall cycles.
  - Read: 3 + RAM_LATENCY + stall cycles.
- ram_ren and ram_wen are never high simultaneously. Each is high for exactly 1 + stall cycles per transfer.
- PRDATA and PSLVERR are meaningful only while PREADY = 1.

## Test plan
Configuration for all scenarios: DATA_WIDTH = 32, RAM_ADDR_WIDTH = 4, BASE_ADDR = 0x1000, RAM_LATENCY = 2, RAM model with latency 2.

- Write 0x1004 with 0xDEADBEEF, PSTRB = 0xF, ram_busy = 0 → ram_wen high for one cycle with ram_addr = 1 and ram_byte_en = 0xF; PREADY high in access cycle 3; PSLVERR = 0.
- Read 0x1004 → ram_ren high for one cycle with ram_addr = 1; PREADY high in access cycle 5; PRDATA = 0xDEADBEEF.
- Separate accesses to 0x1040 (idx 16), 0x1002 (misaligned) and 0x0FFC (below base) → each gets PREADY in cycle 2 with PSLVERR = 1, PRDATA = 0, and no RAM strobe.
- Write 0x1008 with 0x11223344, PSTRB = 0x3, over a word preset to 0xAAAAAAAA → ram_byte_en = 0x3; a following read returns 0xAAAA3344. A write with PSTRB = 0 → no ram_wen; PREADY in cycle 2; PSLVERR = 0.
- Read 0x100C with ram_busy high for 3 cycles in ISSUE → ram_ren held for 4 cycles with ram_addr = 3 stable; PREADY in cycle 8.
- Pull nRST low while in WAIT → all outputs 0 in the same cycle; after release, a write/read of 0x1000 completes normally with the expected data.

Source files
------------

// File: rtl/apb_ram_bridge.sv
`timescale 1ns/1ps
// APB completer bridging onto a synchronous single-port RAM with byte strobes and PSLVERR on bad addresses.
// Latency: error/zero-strobe 2 access cycles, write 3 + stalls, read 3 + RAM_LATENCY + stalls (PREADY only in RESP).
// Backpressure: ram_busy holds the RAM request stable in ISSUE; APB sees extra wait states until acceptance.
//
// Ports: CLK/nRST (async active-low); APB completer PSEL..PSLVERR; RAM master ram_ren/ram_wen/ram_addr/
// ram_wdata/ram_byte_en with ram_rdata returning RAM_LATENCY cycles after acceptance and ram_busy stall.
module apb_ram_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RAM_ADDR_WIDTH = 10,
    parameter int                    RAM_LATENCY    = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      ram_ren,
    output logic                      ram_wen,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    output logic [DATA_WIDTH/8-1:0]   ram_byte_en,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    input  logic                      ram_busy
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam int                    OFF       = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [2:0]            LAT_M1    = 3'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                      r_write;
    logic                      r_err;
    logic [RAM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [BYTES-1:0]          r_be;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [2:0]                r_cnt;

    // One extra bit on the subtraction so an address below the base shows up
    // as a borrow instead of wrapping into a large in-range-looking index.
    logic [ADDR_WIDTH:0]   w_diff;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_below;
    logic                  w_oor;
    logic                  w_misal;
    logic                  w_err;
    logic                  w_start;
    logic                  w_accept;

    assign w_diff   = {1'b0, PADDR} - {1'b0, BASE_ADDR};
    assign w_below  = w_diff[ADDR_WIDTH];
    assign w_idx    = w_diff[ADDR_WIDTH-1:0] >> OFF;
    assign w_oor    = (w_idx >> RAM_ADDR_WIDTH) != '0;
    // BASE_ADDR is word aligned, so alignment of PADDR equals alignment of the offset.
    assign w_misal  = (PADDR & ADDR_MASK) != '0;
    assign w_err    = w_below | w_oor | w_misal;
    assign w_start  = (r_state == S_IDLE) && PSEL && PENABLE;
    assign w_accept = (r_state == S_ISSUE) && !ram_busy;

    // Latched request payload drives the RAM directly so it stays stable through stalls.
    assign ram_addr    = r_addr;
    assign ram_wdata   = r_wdata;
    assign ram_byte_en = r_be;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_err) begin
                        w_next = S_RESP;
                    end else if (PWRITE && (PSTRB == '0)) begin
                        w_next = S_RESP;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                ram_ren = !r_write;
                ram_wen = r_write;
                if (!ram_busy) begin
                    w_next = r_write ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                PREADY  = 1'b1;
                PSLVERR = r_err;
                if (!r_err && !r_write) begin
                    PRDATA = r_rdata;
                end
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_write <= PWRITE;
                r_err   <= w_err;
                r_addr  <= w_idx[RAM_ADDR_WIDTH-1:0];
                r_wdata <= PWDATA;
                r_be    <= PWRITE ? PSTRB : '1;
            end
            if (w_accept && !r_write) begin
                r_cnt <= LAT_M1;
            end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if ((r_state == S_WAIT) && (r_cnt == 3'd0)) begin
                r_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_ram_bridge.sv
`timescale 1ns/1ps
module tb_apb_ram_bridge;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        ram_ren, ram_wen;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byte_en;
    logic [31:0] ram_rdata;
    logic        ram_busy;

    always #5 CLK = ~CLK;

    apb_ram_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .RAM_ADDR_WIDTH (4),
        .RAM_LATENCY    (2),
        .BASE_ADDR      (32'h1000)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .ram_ren     (ram_ren),
        .ram_wen     (ram_wen),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_byte_en (ram_byte_en),
        .ram_rdata   (ram_rdata),
        .ram_busy    (ram_busy)
    );

    // RAM model: read data appears two clock edges after an accepted read,
    // and is garbage on every other cycle so a mistimed capture is visible.
    logic [31:0] mem [16];
    logic [31:0] s0;
    logic        s0_vld;
    always @(posedge CLK) begin
        if (ram_wen && !ram_busy) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        s0_vld    <= ram_ren && !ram_busy;
        s0        <= mem[ram_addr];
        ram_rdata <= s0_vld ? s0 : 32'hBAD0BAD0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Per-transfer observations
    int          ren_cnt, wen_cnt, x_cyc, busy_rem;
    logic [3:0]  st_addr, st_be;
    logic [31:0] st_wdata, x_rdata;
    logic        addr_unstable, both_high, x_err, x_done;

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int stall);
        ren_cnt = 0; wen_cnt = 0; x_cyc = 0; busy_rem = stall;
        st_addr = '0; st_be = '0; st_wdata = '0; x_rdata = '0;
        addr_unstable = 1'b0; both_high = 1'b0; x_err = 1'b0; x_done = 1'b0;
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        ram_busy = 1'b0;
        @(posedge CLK); #1;
        PENABLE  = 1'b1;
        ram_busy = (stall > 0);
        while (!x_done && x_cyc < 40) begin
            x_cyc++;
            @(negedge CLK);
            if (ram_ren && ram_wen) both_high = 1'b1;
            if (ram_ren || ram_wen) begin
                if (ram_ren) ren_cnt++;
                if (ram_wen) wen_cnt++;
                if (ren_cnt + wen_cnt == 1) begin
                    st_addr = ram_addr; st_be = ram_byte_en; st_wdata = ram_wdata;
                end else if (ram_addr !== st_addr) begin
                    addr_unstable = 1'b1;
                end
                if (ram_busy && busy_rem > 0) busy_rem--;
            end
            if (PREADY === 1'b1) begin
                x_done = 1'b1; x_rdata = PRDATA; x_err = PSLVERR;
            end
            @(posedge CLK); #1;
            if (busy_rem == 0) ram_busy = 1'b0;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        check("pready_seen", {63'b0, x_done}, 64'd1);
        check("no_dual_strobe", {63'b0, both_high}, 64'd0);
    endtask

    initial begin
        nRST = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; ram_busy = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pready",  {63'b0, PREADY}, 64'd0);
        check("rst_pslverr", {63'b0, PSLVERR}, 64'd0);
        check("rst_ren",     {63'b0, ram_ren}, 64'd0);
        check("rst_wen",     {63'b0, ram_wen}, 64'd0);
        check("rst_prdata",  {32'b0, PRDATA}, 64'd0);
        check("rst_addr",    {60'b0, ram_addr}, 64'd0);
        check("rst_be",      {60'b0, ram_byte_en}, 64'd0);
        nRST = 1'b1;

        // Full write then read of word 1
        xfer(1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 0);
        check("wr_cycles",  x_cyc, 64'd3);
        check("wr_err",     {63'b0, x_err}, 64'd0);
        check("wr_wen_cnt", wen_cnt, 64'd1);
        check("wr_ren_cnt", ren_cnt, 64'd0);
        check("wr_addr",    {60'b0, st_addr}, 64'd1);
        check("wr_be",      {60'b0, st_be}, 64'hF);
        check("wr_wdata",   {32'b0, st_wdata}, 64'hDEADBEEF);

        xfer(1'b0, 32'h1004, 32'h0, 4'h0, 0);
        check("rd_cycles",  x_cyc, 64'd5);
        check("rd_ren_cnt", ren_cnt, 64'd1);
        check("rd_wen_cnt", wen_cnt, 64'd0);
        check("rd_addr",    {60'b0, st_addr}, 64'd1);
        check("rd_be",      {60'b0, st_be}, 64'hF);
        check("rd_data",    {32'b0, x_rdata}, 64'hDEADBEEF);
        check("rd_err",     {63'b0, x_err}, 64'd0);

        // Error responses: out of range, misaligned, below base
        xfer(1'b0, 32'h1040, 32'h0, 4'hF, 0);
        check("oor_cycles", x_cyc, 64'd2);
        check("oor_err",    {63'b0, x_err}, 64'd1);
        check("oor_prdata", {32'b0, x_rdata}, 64'd0);
        check("oor_strobe", ren_cnt + wen_cnt, 64'd0);
        xfer(1'b1, 32'h1002, 32'h55555555, 4'hF, 0);
        check("mis_cycles", x_cyc, 64'd2);
        check("mis_err",    {63'b0, x_err}, 64'd1);
        check("mis_prdata", {32'b0, x_rdata}, 64'd0);
        check("mis_strobe", ren_cnt + wen_cnt, 64'd0);
        xfer(1'b0, 32'h0FFC, 32'h0, 4'hF, 0);
        check("blw_cycles", x_cyc, 64'd2);
        check("blw_err",    {63'b0, x_err}, 64'd1);
        check("blw_prdata", {32'b0, x_rdata}, 64'd0);
        check("blw_strobe", ren_cnt + wen_cnt, 64'd0);

        // Partial byte write over a preset word
        xfer(1'b1, 32'h1008, 32'hAAAAAAAA, 4'hF, 0);
        check("pre_cycles", x_cyc, 64'd3);
        xfer(1'b1, 32'h1008, 32'h11223344, 4'h3, 0);
        check("pw_be",      {60'b0, st_be}, 64'h3);
        check("pw_addr",    {60'b0, st_addr}, 64'd2);
        check("pw_cycles",  x_cyc, 64'd3);
        xfer(1'b0, 32'h1008, 32'h0, 4'h0, 0);
        check("pw_rdata",   {32'b0, x_rdata}, 64'hAAAA3344);

        // Zero-strobe write: no RAM access, no error, word unchanged
        xfer(1'b1, 32'h1008, 32'hFFFFFFFF, 4'h0, 0);
        check("zs_cycles",  x_cyc, 64'd2);
        check("zs_err",     {63'b0, x_err}, 64'd0);
        check("zs_wen",     wen_cnt, 64'd0);
        xfer(1'b0, 32'h1008, 32'h0, 4'h0, 0);
        check("zs_rdata",   {32'b0, x_rdata}, 64'hAAAA3344);

        // Read with three stall cycles in ISSUE
        xfer(1'b1, 32'h100C, 32'h5A5A0003, 4'hF, 0);
        xfer(1'b0, 32'h100C, 32'h0, 4'h0, 3);
        check("st_ren_cnt", ren_cnt, 64'd4);
        check("st_addr",    {60'b0, st_addr}, 64'd3);
        check("st_stable",  {63'b0, addr_unstable}, 64'd0);
        check("st_cycles",  x_cyc, 64'd8);
        check("st_rdata",   {32'b0, x_rdata}, 64'h5A5A0003);

        // Reset asserted while the bridge waits for read data
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h1004;
        PWDATA = 32'h12345678; PSTRB = 4'hF;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("pre_rst_addr", {60'b0, ram_addr}, 64'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("mr_pready",  {63'b0, PREADY}, 64'd0);
        check("mr_pslverr", {63'b0, PSLVERR}, 64'd0);
        check("mr_ren",     {63'b0, ram_ren}, 64'd0);
        check("mr_wen",     {63'b0, ram_wen}, 64'd0);
        check("mr_prdata",  {32'b0, PRDATA}, 64'd0);
        check("mr_addr",    {60'b0, ram_addr}, 64'd0);
        check("mr_wdata",   {32'b0, ram_wdata}, 64'd0);
        check("mr_be",      {60'b0, ram_byte_en}, 64'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;

        xfer(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
        check("ar_wr_cycles", x_cyc, 64'd3);
        check("ar_wr_addr",   {60'b0, st_addr}, 64'd0);
        check("ar_wr_err",    {63'b0, x_err}, 64'd0);
        xfer(1'b0, 32'h1000, 32'h0, 4'h0, 0);
        check("ar_rd_cycles", x_cyc, 64'd5);
        check("ar_rd_data",   {32'b0, x_rdata}, 64'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
